// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_7    = 7;
  localparam int DATA_BITS_8    = 8;
  localparam int BIT_CNT_W      = 4;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick down-counter and frame bit counter; bit_end_o strobes on the
// last tick of every bit period.
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 tick_i,
  output logic                 bit_end_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(OVERSAMPLE - 1);

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign bit_end_o = en_i && tick_i && (tick_cnt_q == '0);
  assign bit_cnt_o = bit_cnt_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clear_i) begin
      tick_cnt_d = TICK_LOAD;
      bit_cnt_d  = '0;
    end else if (en_i && tick_i) begin
      if (tick_cnt_q == '0) begin
        tick_cnt_d = TICK_LOAD;
        bit_cnt_d  = bit_cnt_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_fifo_tx_reader.sv
// Pops bytes from the TX FIFO and serialises each as a UART frame.
//   state  | meaning
//   IDLE   | wait for non-empty FIFO, issue one read strobe
//   FETCH  | wait out FIFO read latency, capture byte and frame config
//   START  | start bit (TX=0)
//   DATA   | 7 or 8 data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | stop bit(s), TX_DONE on the final tick
module uart_fifo_tx_reader
  import uart_tx_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       baud_tick_i,
  input  logic       bit8_i,
  input  logic       parity_en_i,
  input  logic       odd_n_even_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_do_i,
  output logic       fifo_rdb_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int FW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [FW-1:0] FETCH_LOAD = FW'(READ_LATENCY);

  tx_state_e            state_q, state_d;
  logic [FW-1:0]        fetch_cnt_q, fetch_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 rdb_q, rdb_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit8_q, bit8_d;
  logic                 par_en_q, par_en_d;
  logic                 parity_q, parity_d;
  logic                 timer_clear, timer_en, bit_end;
  logic [BIT_CNT_W-1:0] bit_cnt, n_data, last_pos;
  logic [7:0]           data_mask;

  assign timer_en  = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
  assign data_mask = bit8_i ? 8'hFF : 8'h7F;
  assign n_data    = bit8_q ? BIT_CNT_W'(DATA_BITS_8) : BIT_CNT_W'(DATA_BITS_7);
  // Bit positions: 0 start, 1..n_data data, then parity, then stop bits.
  assign last_pos  = n_data + {{(BIT_CNT_W-1){1'b0}}, par_en_q} + BIT_CNT_W'(STOP_BITS);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .tick_i    (baud_tick_i),
    .bit_end_o (bit_end),
    .bit_cnt_o (bit_cnt)
  );

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rdb_d       = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bit8_d      = bit8_q;
    par_en_d    = par_en_q;
    parity_d    = parity_q;
    timer_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          rdb_d       = 1'b0;
          busy_d      = 1'b1;
          fetch_cnt_d = FETCH_LOAD;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (fetch_cnt_q == '0) begin
          shift_d     = fifo_do_i;
          bit8_d      = bit8_i;
          par_en_d    = parity_en_i;
          parity_d    = odd_n_even_i ^ (^(fifo_do_i & data_mask));
          timer_clear = 1'b1;
          tx_d        = 1'b0;
          state_d     = START;
        end else begin
          fetch_cnt_d = fetch_cnt_q - 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == n_data) begin
            tx_d    = par_en_q ? parity_q : 1'b1;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            tx_d    = shift_q[1];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end && (bit_cnt == last_pos)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      rdb_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit8_q      <= 1'b0;
      par_en_q    <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rdb_q       <= rdb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit8_q      <= bit8_d;
      par_en_q    <= par_en_d;
      parity_q    <= parity_d;
    end
  end

  assign fifo_rdb_o = rdb_q;
  assign tx_o       = tx_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

endmodule
